// File: rtl/adc_ad4003_acq_ctrl.sv
// AD4003 conversion/readout sequencer: CNV pulse, SCK gate, delayed read window.
// Optional overrun counter port enabled by defining ADC_OVERRUN_CNT_EN.
module adc_ad4003_acq_ctrl #(
  parameter int ADC_DATA_WIDTH = 18,
  parameter int CNV_CYCLES     = 26,
  parameter int READ_LAT       = 4,
  parameter int TCQ            = 1
) (
  input  logic        adc_clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic        trigger,
  output logic        adc_cnv,
  output logic        adc_sck_en,
  output logic        reader_en,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
`ifdef ADC_OVERRUN_CNT_EN
  ,
  output logic [15:0] overrun_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    SHIFT,
    DRAIN
  } state_t;

  state_t     state;
  logic [7:0] cnv_cnt;
  logic [4:0] bit_cnt;
  logic [3:0] drain_cnt;

  generate
    if (CNV_CYCLES < 2 || CNV_CYCLES > 255 || READ_LAT < 0 || READ_LAT > 15 ||
        ADC_DATA_WIDTH < 1 || ADC_DATA_WIDTH > 32 || TCQ < 0) begin : g_param_err
      $error("adc_ad4003_acq_ctrl: parameter out of legal range");
    end
  endgenerate

  always_ff @(posedge adc_clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnv_cnt    <= '0;
      bit_cnt    <= '0;
      drain_cnt  <= '0;
      adc_cnv    <= 1'b0;
      adc_sck_en <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= trigger && (state != IDLE);
      case (state)
        IDLE: begin
          if (trigger && enable) begin
            state   <= CONV;
            adc_cnv <= 1'b1;
            busy    <= 1'b1;
            cnv_cnt <= 8'(CNV_CYCLES - 1);
          end
        end
        CONV: begin
          if (cnv_cnt == '0) begin
            state      <= SHIFT;
            adc_cnv    <= 1'b0;
            adc_sck_en <= 1'b1;
            bit_cnt    <= 5'(ADC_DATA_WIDTH - 1);
          end else begin
            cnv_cnt <= cnv_cnt - 8'd1;
          end
        end
        SHIFT: begin
          if (bit_cnt == '0) begin
            state      <= DRAIN;
            adc_sck_en <= 1'b0;
            drain_cnt  <= 4'(READ_LAT);
            // With no read latency the window has already closed, so the
            // done pulse coincides with the single DRAIN cycle.
            frame_done <= (READ_LAT == 0);
          end else begin
            bit_cnt <= bit_cnt - 5'd1;
          end
        end
        DRAIN: begin
          if (frame_done) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
          end else if (drain_cnt <= 4'd1) begin
            frame_done <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  generate
    if (READ_LAT == 0) begin : g_rd_direct
      assign reader_en = adc_sck_en;
    end else begin : g_rd_pipe
      logic [READ_LAT-1:0] rd_pipe;
      always_ff @(posedge adc_clk or negedge rstn) begin
        if (!rstn) rd_pipe <= '0;
        else       rd_pipe <= READ_LAT'({rd_pipe, adc_sck_en});
      end
      assign reader_en = rd_pipe[READ_LAT-1];
    end
  endgenerate

`ifdef ADC_OVERRUN_CNT_EN
  always_ff @(posedge adc_clk or negedge rstn) begin
    if (!rstn)                           overrun_cnt <= '0;
    else if (!enable)                    overrun_cnt <= '0;
    else if (overrun && overrun_cnt != '1) overrun_cnt <= overrun_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_adc_ad4003_acq_ctrl.sv
// Directed bench for adc_ad4003_acq_ctrl: default build plus a READ_LAT=0 instance.
module tb_adc_ad4003_acq_ctrl;

  logic adc_clk = 1'b0;
  logic rstn    = 1'b0;
  logic enable  = 1'b0;
  logic trigger = 1'b0;
  logic adc_cnv, adc_sck_en, reader_en, busy, frame_done, overrun;
  logic z_cnv, z_sck, z_rd, z_busy, z_fd, z_ov;
`ifdef ADC_OVERRUN_CNT_EN
  logic [15:0] overrun_cnt, z_ocnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] w_cnv, w_sck, w_rd, w_fd, w_busy, w_ov, w_zsck, w_zrd, w_zfd;

  always #5 adc_clk = ~adc_clk;

  adc_ad4003_acq_ctrl #(.ADC_DATA_WIDTH(18), .CNV_CYCLES(26), .READ_LAT(4), .TCQ(1)) dut (
    .adc_clk(adc_clk), .rstn(rstn), .enable(enable), .trigger(trigger),
    .adc_cnv(adc_cnv), .adc_sck_en(adc_sck_en), .reader_en(reader_en),
    .busy(busy), .frame_done(frame_done), .overrun(overrun)
`ifdef ADC_OVERRUN_CNT_EN
    , .overrun_cnt(overrun_cnt)
`endif
  );

  adc_ad4003_acq_ctrl #(.ADC_DATA_WIDTH(18), .CNV_CYCLES(26), .READ_LAT(0), .TCQ(1)) dut0 (
    .adc_clk(adc_clk), .rstn(rstn), .enable(enable), .trigger(trigger),
    .adc_cnv(z_cnv), .adc_sck_en(z_sck), .reader_en(z_rd),
    .busy(z_busy), .frame_done(z_fd), .overrun(z_ov)
`ifdef ADC_OVERRUN_CNT_EN
    , .overrun_cnt(z_ocnt)
`endif
  );

  function automatic logic [63:0] span(input int lo, input int hi);
    logic [63:0] v = '0;
    for (int i = lo; i <= hi; i++) v[i] = 1'b1;
    return v;
  endfunction

  // Entered at posedge+1; trigger high in cycle 0, outputs of cycle k land in bit k.
  task automatic capture(input int trig2_at, input int en_off_at);
    trigger = 1'b1;
    for (int k = 0; k < 56; k++) begin
      @(negedge adc_clk);
      w_cnv[k] = adc_cnv;  w_sck[k] = adc_sck_en; w_rd[k] = reader_en;
      w_fd[k]  = frame_done; w_busy[k] = busy;  w_ov[k] = overrun;
      w_zsck[k] = z_sck;   w_zrd[k] = z_rd;     w_zfd[k] = z_fd;
      @(posedge adc_clk); #1;
      trigger = (k + 1 == trig2_at);
      if (k + 1 == en_off_at) enable = 1'b0;
    end
    for (int k = 56; k < 64; k++) begin
      w_cnv[k] = 1'b0; w_sck[k] = 1'b0; w_rd[k] = 1'b0; w_fd[k] = 1'b0; w_busy[k] = 1'b0;
      w_ov[k] = 1'b0; w_zsck[k] = 1'b0; w_zrd[k] = 1'b0; w_zfd[k] = 1'b0;
    end
  endtask

  task automatic test_reset;
    #2;
    n_cmp++; if ({adc_cnv, adc_sck_en, reader_en, busy, frame_done, overrun} !== 6'b0) begin
      n_bad++; $display("FAIL reset_outs got=%b exp=000000", {adc_cnv, adc_sck_en, reader_en, busy, frame_done, overrun}); end
    n_cmp++; if ({z_cnv, z_sck, z_rd, z_busy, z_fd, z_ov} !== 6'b0) begin
      n_bad++; $display("FAIL reset_outs_lat0 got=%b exp=000000", {z_cnv, z_sck, z_rd, z_busy, z_fd, z_ov}); end
`ifdef ADC_OVERRUN_CNT_EN
    n_cmp++; if (overrun_cnt !== 16'd0) begin
      n_bad++; $display("FAIL reset_ocnt got=%0d exp=0", overrun_cnt); end
`endif
    repeat (3) @(posedge adc_clk);
    #1 rstn = 1'b1;
    @(posedge adc_clk); #1;
  endtask

  task automatic test_single_frame;
    enable = 1'b1;
    capture(-1, -1);
    n_cmp++; if (w_cnv !== span(1, 26)) begin n_bad++; $display("FAIL single_cnv got=%h exp=%h", w_cnv, span(1, 26)); end
    n_cmp++; if (w_sck !== span(27, 44)) begin n_bad++; $display("FAIL single_sck got=%h exp=%h", w_sck, span(27, 44)); end
    n_cmp++; if (w_rd !== span(31, 48)) begin n_bad++; $display("FAIL single_rd got=%h exp=%h", w_rd, span(31, 48)); end
    n_cmp++; if (w_fd !== span(49, 49)) begin n_bad++; $display("FAIL single_fd got=%h exp=%h", w_fd, span(49, 49)); end
    n_cmp++; if (w_busy !== span(1, 49)) begin n_bad++; $display("FAIL single_busy got=%h exp=%h", w_busy, span(1, 49)); end
    n_cmp++; if (w_ov !== 64'd0) begin n_bad++; $display("FAIL single_ov got=%h exp=0", w_ov); end
    n_cmp++; if (w_zsck !== span(27, 44)) begin n_bad++; $display("FAIL lat0_sck got=%h exp=%h", w_zsck, span(27, 44)); end
    n_cmp++; if (w_zrd !== span(27, 44)) begin n_bad++; $display("FAIL lat0_rd got=%h exp=%h", w_zrd, span(27, 44)); end
    n_cmp++; if (w_zfd !== span(45, 45)) begin n_bad++; $display("FAIL lat0_fd got=%h exp=%h", w_zfd, span(45, 45)); end
  endtask

  task automatic test_overrun;
    enable = 1'b1;
    capture(10, -1);
    n_cmp++; if (w_ov !== span(11, 11)) begin n_bad++; $display("FAIL ovr_pulse got=%h exp=%h", w_ov, span(11, 11)); end
    n_cmp++; if (w_cnv !== span(1, 26)) begin n_bad++; $display("FAIL ovr_cnv got=%h exp=%h", w_cnv, span(1, 26)); end
    n_cmp++; if (w_sck !== span(27, 44)) begin n_bad++; $display("FAIL ovr_sck got=%h exp=%h", w_sck, span(27, 44)); end
    n_cmp++; if (w_rd !== span(31, 48)) begin n_bad++; $display("FAIL ovr_rd got=%h exp=%h", w_rd, span(31, 48)); end
    n_cmp++; if (w_fd !== span(49, 49)) begin n_bad++; $display("FAIL ovr_fd got=%h exp=%h", w_fd, span(49, 49)); end
`ifdef ADC_OVERRUN_CNT_EN
    n_cmp++; if (overrun_cnt !== 16'd1) begin n_bad++; $display("FAIL ovr_cnt got=%0d exp=1", overrun_cnt); end
`endif
  endtask

  task automatic test_back_to_back;
    int fd_cnt = 0, ov_cnt = 0, zfd_cnt = 0;
    enable = 1'b1;
    for (int f = 0; f < 100; f++) begin
      for (int k = 0; k < 50; k++) begin
        trigger = (k == 0);
        @(negedge adc_clk);
        fd_cnt += int'(frame_done); ov_cnt += int'(overrun); zfd_cnt += int'(z_fd);
        @(posedge adc_clk); #1;
      end
    end
    trigger = 1'b0;
    n_cmp++; if (fd_cnt !== 100) begin n_bad++; $display("FAIL b2b_fd got=%0d exp=100", fd_cnt); end
    n_cmp++; if (ov_cnt !== 0) begin n_bad++; $display("FAIL b2b_ov got=%0d exp=0", ov_cnt); end
    n_cmp++; if (zfd_cnt !== 100) begin n_bad++; $display("FAIL b2b_lat0_fd got=%0d exp=100", zfd_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle got=%b exp=0", busy); end
  endtask

  task automatic test_enable_drop;
    enable = 1'b1;
    capture(-1, 31);
    n_cmp++; if (w_cnv !== span(1, 26)) begin n_bad++; $display("FAIL endrop_cnv got=%h exp=%h", w_cnv, span(1, 26)); end
    n_cmp++; if (w_sck !== span(27, 44)) begin n_bad++; $display("FAIL endrop_sck got=%h exp=%h", w_sck, span(27, 44)); end
    n_cmp++; if (w_rd !== span(31, 48)) begin n_bad++; $display("FAIL endrop_rd got=%h exp=%h", w_rd, span(31, 48)); end
    n_cmp++; if (w_fd !== span(49, 49)) begin n_bad++; $display("FAIL endrop_fd got=%h exp=%h", w_fd, span(49, 49)); end
    capture(-1, -1);
    n_cmp++; if (w_cnv !== 64'd0) begin n_bad++; $display("FAIL disabled_cnv got=%h exp=0", w_cnv); end
    n_cmp++; if (w_busy !== 64'd0) begin n_bad++; $display("FAIL disabled_busy got=%h exp=0", w_busy); end
    n_cmp++; if (w_ov !== 64'd0) begin n_bad++; $display("FAIL disabled_ov got=%h exp=0", w_ov); end
`ifdef ADC_OVERRUN_CNT_EN
    n_cmp++; if (overrun_cnt !== 16'd0) begin n_bad++; $display("FAIL disabled_ocnt got=%0d exp=0", overrun_cnt); end
`endif
  endtask

  task automatic test_reset_midframe;
    int fd_seen = 0;
    enable  = 1'b1;
    trigger = 1'b1;
    @(posedge adc_clk); #1;
    trigger = 1'b0;
    repeat (11) begin @(posedge adc_clk); #1; end
    n_cmp++; if (adc_cnv !== 1'b1) begin n_bad++; $display("FAIL midrst_pre_cnv got=%b exp=1", adc_cnv); end
    rstn = 1'b0;
    #1;
    n_cmp++; if ({adc_cnv, adc_sck_en, reader_en, busy, frame_done, overrun} !== 6'b0) begin
      n_bad++; $display("FAIL midrst_outs got=%b exp=000000", {adc_cnv, adc_sck_en, reader_en, busy, frame_done, overrun}); end
    repeat (40) begin @(negedge adc_clk); fd_seen += int'(frame_done); end
    n_cmp++; if (fd_seen !== 0) begin n_bad++; $display("FAIL midrst_fd got=%0d exp=0", fd_seen); end
    @(posedge adc_clk); #1 rstn = 1'b1;
    @(posedge adc_clk); #1;
    capture(-1, -1);
    n_cmp++; if (w_cnv !== span(1, 26)) begin n_bad++; $display("FAIL postrst_cnv got=%h exp=%h", w_cnv, span(1, 26)); end
    n_cmp++; if (w_sck !== span(27, 44)) begin n_bad++; $display("FAIL postrst_sck got=%h exp=%h", w_sck, span(27, 44)); end
    n_cmp++; if (w_rd !== span(31, 48)) begin n_bad++; $display("FAIL postrst_rd got=%h exp=%h", w_rd, span(31, 48)); end
    n_cmp++; if (w_fd !== span(49, 49)) begin n_bad++; $display("FAIL postrst_fd got=%h exp=%h", w_fd, span(49, 49)); end
  endtask

  initial begin
    test_reset;
    test_single_frame;
    test_overrun;
    test_back_to_back;
    test_enable_drop;
    test_reset_midframe;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
